// File: rtl/tlb_ctrl_pkg.sv
// Shared CPU definitions used by the TLB management sequencer.
// Optional feature macro: TLB_CTRL_FLUSH_EN (adds the DRAIN state).
`ifndef TLB_ENTRIES_NUM
`define TLB_ENTRIES_NUM 16
`endif

package cpu_defs;

    localparam int TLB_IDX_W = $clog2(`TLB_ENTRIES_NUM);

    typedef logic [TLB_IDX_W-1:0] tlb_index_t;

    // One TLB entry: VPN2/ASID tag, page mask, global bit and an even/odd PFN pair.
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] pagemask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        TLBR  = 2'd0,
        TLBWI = 2'd1,
        TLBWR = 2'd2,
        TLBP  = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
`ifdef TLB_CTRL_FLUSH_EN
        ,
        DRAIN
`endif
    } tlb_ctrl_state_t;

    // True for the ops that modify the TLB array.
    function automatic logic is_write(input tlb_op_t op);
        return (op == TLBWI) || (op == TLBWR);
    endfunction

endpackage

// File: rtl/tlb_ctrl_if.sv
// Commit-stage request/response bus of the TLB sequencer.
// master = commit stage / CP0 side, slave = tlb_ctrl.
interface tlb_ctrl_if
    import cpu_defs::*;
#(
    parameter int IDX_W = TLB_IDX_W
);
    logic             req_valid;
    logic             req_ready;
    tlb_op_t          req_op;
    logic [IDX_W-1:0] req_index;
    tlb_entry_t       req_entry;
    logic [31:0]      req_entry_hi;

    logic             resp_valid;
    tlb_op_t          resp_op;
    tlb_entry_t       resp_entry;
    logic [31:0]      resp_index;

    modport master (
        output req_valid, req_op, req_index, req_entry, req_entry_hi,
        input  req_ready, resp_valid, resp_op, resp_entry, resp_index
    );

    modport slave (
        input  req_valid, req_op, req_index, req_entry, req_entry_hi,
        output req_ready, resp_valid, resp_op, resp_entry, resp_index
    );
endinterface

// File: rtl/tlb_ctrl_random_counter.sv
// CP0 Random register: decrements every cycle, reloads TLB_ENTRIES-1 on
// reset, on a Wired write, or when it reaches Wired.
module tlb_random_counter #(
    parameter int TLB_ENTRIES = `TLB_ENTRIES_NUM,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] random_d;

    // Next value: reload at Wired (covers wrap and Wired == TOP), else count down.
    always_comb begin
        random_d = random_q - 1'b1;
        if (wired_we || (random_q == wired)) begin
            random_d = TOP;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random = random_q;
endmodule

// File: rtl/tlb_ctrl.sv
// TLB management sequencer (TLBR/TLBWI/TLBWR/TLBP): IDLE -> EXEC -> RESP.
// Optional feature macro: TLB_CTRL_FLUSH_EN adds flush_req and a DRAIN state.
module tlb_ctrl
    import cpu_defs::*;
#(
    parameter int TLB_ENTRIES = `TLB_ENTRIES_NUM,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    tlb_ctrl_if.slave        bus,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             cp0_wired_we,
    output logic [IDX_W-1:0] cp0_random,
    output logic [IDX_W-1:0] tlbrw_index,
    output logic             tlbrw_we,
    output tlb_entry_t       tlbrw_wdata,
    input  tlb_entry_t       tlbrw_rdata,
    output logic [31:0]      tlbp_entry_hi,
    input  logic [31:0]      tlbp_index
`ifdef TLB_CTRL_FLUSH_EN
    ,
    output logic             flush_req
`endif
);
    tlb_ctrl_state_t state_q, state_d;

    // Operand registers, loaded in the accept cycle.
    tlb_op_t          op_q;
    logic [IDX_W-1:0] idx_q;
    tlb_entry_t       entry_q;
    logic [31:0]      ehi_q;

    // Capture registers, loaded at the end of EXEC.
    tlb_op_t          rop_q;
    tlb_entry_t       rentry_q;
    logic [31:0]      rindex_q;

    logic             accept;
    logic             ready_c;
    logic             we_c;
    logic             rvalid_c;
    logic             flush_c;
    logic [IDX_W-1:0] idx_d;

    tlb_random_counter #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (cp0_wired),
        .wired_we (cp0_wired_we),
        .random   (cp0_random)
    );

    assign accept = (state_q == IDLE) && bus.req_valid;
    // TLBWR targets the Random value seen in the accept cycle, before any Wired write lands.
    assign idx_d  = (bus.req_op == TLBWR) ? cp0_random : bus.req_index;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        we_c     = 1'b0;
        rvalid_c = 1'b0;
        flush_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                we_c    = is_write(op_q);
                state_d = RESP;
            end
            RESP: begin
                rvalid_c = 1'b1;
                flush_c  = is_write(op_q);
`ifdef TLB_CTRL_FLUSH_EN
                state_d  = DRAIN;
`else
                state_d  = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch on accept; these also drive the TLB ports directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= TLBR;
            idx_q   <= '0;
            entry_q <= '0;
            ehi_q   <= '0;
        end else if (accept) begin
            op_q    <= bus.req_op;
            idx_q   <= idx_d;
            entry_q <= bus.req_entry;
            ehi_q   <= bus.req_entry_hi;
        end
    end

    // Capture the TLB result at the end of EXEC; fields unrelated to the op read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rop_q    <= TLBR;
            rentry_q <= '0;
            rindex_q <= '0;
        end else if (state_q == EXEC) begin
            rop_q    <= op_q;
            rentry_q <= (op_q == TLBR) ? tlbrw_rdata : '0;
            rindex_q <= (op_q == TLBP) ? tlbp_index : '0;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = rvalid_c;
    assign bus.resp_op    = rop_q;
    assign bus.resp_entry = rentry_q;
    assign bus.resp_index = rindex_q;

    assign tlbrw_we      = we_c;
    assign tlbrw_index   = idx_q;
    assign tlbrw_wdata   = entry_q;
    assign tlbp_entry_hi = ehi_q;

`ifdef TLB_CTRL_FLUSH_EN
    assign flush_req = flush_c;
`else
    logic unused_flush;
    assign unused_flush = flush_c;
`endif
endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: behavioural TLB array plus a transaction-level
// scoreboard (accept cycle -> access/response/ready cycles, shadow TLB,
// Random counter arithmetic).
module tb_tlb_ctrl;
    import cpu_defs::*;

    localparam int N  = `TLB_ENTRIES_NUM;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] cp0_wired;
    logic          cp0_wired_we;
    logic [IW-1:0] cp0_random;
    logic [IW-1:0] tlbrw_index;
    logic          tlbrw_we;
    tlb_entry_t    tlbrw_wdata;
    tlb_entry_t    tlbrw_rdata;
    logic [31:0]   tlbp_entry_hi;
    logic [31:0]   tlbp_index;
`ifdef TLB_CTRL_FLUSH_EN
    logic          flush_req;
`endif

    always #5 clk = ~clk;

    tlb_ctrl_if #(.IDX_W(IW)) bus ();

    tlb_ctrl #(.TLB_ENTRIES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .cp0_wired     (cp0_wired),
        .cp0_wired_we  (cp0_wired_we),
        .cp0_random    (cp0_random),
        .tlbrw_index   (tlbrw_index),
        .tlbrw_we      (tlbrw_we),
        .tlbrw_wdata   (tlbrw_wdata),
        .tlbrw_rdata   (tlbrw_rdata),
        .tlbp_entry_hi (tlbp_entry_hi),
        .tlbp_index    (tlbp_index)
`ifdef TLB_CTRL_FLUSH_EN
        ,
        .flush_req     (flush_req)
`endif
    );

    // ---------------- behavioural TLB array (environment) ----------------
    tlb_entry_t tlb_mem [N] = '{default: '0};

    function automatic logic hit(input tlb_entry_t e, input logic [31:0] ehi);
        return (e.vpn2 == ehi[31:13]) && (e.g || (e.asid == ehi[7:0]));
    endfunction

    always @(posedge clk) begin
        if (tlbrw_we === 1'b1) tlb_mem[tlbrw_index] <= tlbrw_wdata;
    end

    assign tlbrw_rdata = tlb_mem[tlbrw_index];

    always_comb begin
        tlbp_index = 32'h8000_0000;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit(tlb_mem[i], tlbp_entry_hi)) tlbp_index = 32'(i);
        end
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k = 0;
    bit          armed = 0;
    int          wired_cur = 0;
    int          m_rnd = N - 1;
    int          ready_at = 0;
    int          exec_at = -1;
    int          resp_at = -1;
    tlb_op_t     e_op = TLBR;
    int          e_idx = 0;
    logic        e_write = 1'b0;
    tlb_entry_t  e_wdata = '0;
    tlb_entry_t  e_rentry = '0;
    logic [31:0] e_ehi = '0;
    logic [31:0] e_rindex = '0;
    tlb_entry_t  shadow [N] = '{default: '0};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, k, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_probe(input logic [31:0] ehi);
        logic [31:0] r;
        r = 32'h8000_0000;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit(shadow[i], ehi)) r = 32'(i);
        end
        return r;
    endfunction

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t e;
        e          = '0;
        e.vpn2     = 19'($urandom_range(0, 3));
        e.asid     = 8'($urandom_range(0, 3));
        e.g        = 1'($urandom_range(0, 1));
        e.pagemask = 12'($urandom);
        e.pfn0     = 20'($urandom);
        e.c0       = 3'($urandom);
        e.d0       = 1'($urandom);
        e.v0       = 1'($urandom);
        e.pfn1     = 20'($urandom);
        e.c1       = 3'($urandom);
        e.d1       = 1'($urandom);
        e.v1       = 1'($urandom);
        return e;
    endfunction

    // One clock cycle: check this cycle's outputs, drive inputs, advance the model.
    task automatic step(input bit r, input bit v, input tlb_op_t op, input int idx,
                        input tlb_entry_t ent, input logic [31:0] ehi, input bit wwe);
        if (armed) begin
            check("req_ready", 128'(bus.req_ready), 128'(k >= ready_at));
            check("cp0_random", 128'(cp0_random), 128'(m_rnd));
            check("tlbrw_we", 128'(tlbrw_we), 128'((k == exec_at) && e_write));
            if (k == exec_at) begin
                if (e_op != TLBP) check("tlbrw_index", 128'(tlbrw_index), 128'(e_idx));
                if (e_write) check("tlbrw_wdata", 128'(tlbrw_wdata), 128'(e_wdata));
                if (e_op == TLBP) check("tlbp_entry_hi", 128'(tlbp_entry_hi), 128'(e_ehi));
            end
            check("resp_valid", 128'(bus.resp_valid), 128'(k == resp_at));
            if (k == resp_at) begin
                check("resp_op", 128'(bus.resp_op), 128'(e_op));
                check("resp_entry", 128'(bus.resp_entry), 128'(e_rentry));
                check("resp_index", 128'(bus.resp_index), 128'(e_rindex));
            end
`ifdef TLB_CTRL_FLUSH_EN
            check("flush_req", 128'(flush_req), 128'((k == resp_at) && e_write));
`endif
        end

        rst              = r;
        bus.req_valid    = v;
        bus.req_op       = op;
        bus.req_index    = IW'(idx);
        bus.req_entry    = ent;
        bus.req_entry_hi = ehi;
        cp0_wired        = IW'(wired_cur);
        cp0_wired_we     = wwe;

        if (r) begin
            ready_at = k + 1;
            exec_at  = -1;
            resp_at  = -1;
        end else if (v && (k >= ready_at)) begin
            e_op     = op;
            e_idx    = (op == TLBWR) ? m_rnd : idx;
            e_write  = (op == TLBWI) || (op == TLBWR);
            e_wdata  = ent;
            e_ehi    = ehi;
            if (e_write) shadow[e_idx] = ent;
            e_rentry = (op == TLBR) ? shadow[e_idx] : '0;
            e_rindex = (op == TLBP) ? model_probe(ehi) : 32'h0;
            exec_at  = k + 1;
            resp_at  = k + 2;
`ifdef TLB_CTRL_FLUSH_EN
            ready_at = k + 4;
`else
            ready_at = k + 3;
`endif
        end

        if (r || wwe || (m_rnd == wired_cur)) m_rnd = N - 1;
        else m_rnd = (m_rnd + N - 1) % N;

        @(posedge clk);
        #1;
        k++;
        armed = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, TLBR, 0, '0, 32'h0, 0);
    endtask

    tlb_entry_t e5;

    initial begin
        // Reset and reset values.
        step(1, 0, TLBR, 0, '0, 32'h0, 0);
        step(1, 0, TLBR, 0, '0, 32'h0, 0);
        check("rst_random", 128'(cp0_random), 128'(N - 1));
        check("rst_ready", 128'(bus.req_ready), 128'(1));
        check("rst_we", 128'(tlbrw_we), 128'(0));
        check("rst_tlbrw_index", 128'(tlbrw_index), 128'(0));
        check("rst_wdata", 128'(tlbrw_wdata), 128'(0));
        check("rst_tlbp_ehi", 128'(tlbp_entry_hi), 128'(0));
        check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        check("rst_resp_op", 128'(bus.resp_op), 128'(0));
        check("rst_resp_entry", 128'(bus.resp_entry), 128'(0));
        check("rst_resp_index", 128'(bus.resp_index), 128'(0));

        // Wired = 0: full countdown with wrap; then Wired = 4.
        idle(2 * N + 2);
        wired_cur = 4;
        step(0, 0, TLBR, 0, '0, 32'h0, 1);
        idle(2 * N);

        // TLBWI to index 5, read it back, probe hit and miss.
        wired_cur = 0;
        step(0, 0, TLBR, 0, '0, 32'h0, 1);
        e5      = rand_entry();
        e5.vpn2 = 19'h0_0123;
        e5.asid = 8'h07;
        e5.g    = 1'b0;
        step(0, 1, TLBWI, 5, e5, 32'h0, 0);
        idle(3);
        step(0, 1, TLBR, 5, '0, 32'h0, 0);
        idle(3);
        step(0, 1, TLBP, 0, '0, {19'h0_0123, 5'd0, 8'h07}, 0);
        idle(3);
        step(0, 1, TLBP, 0, '0, {19'h7_ffff, 5'd0, 8'h07}, 0);
        idle(3);

        // TLBWR while Wired is written in the accept cycle: must use Random == 9.
        for (int i = 0; (i < 3 * N) && (m_rnd != 9); i++) idle(1);
        check("rnd_at_9", 128'(cp0_random), 128'(9));
        step(0, 1, TLBWR, 0, rand_entry(), 32'h0, 1);
        idle(3);

        // Reset during EXEC of a TLBR aborts with no response.
        step(0, 1, TLBR, 5, '0, 32'h0, 0);
        step(1, 0, TLBR, 0, '0, 32'h0, 0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit      r;
            bit      wwe;
            tlb_op_t op;
            r   = ($urandom_range(0, 199) == 0);
            wwe = ($urandom_range(0, 49) == 0);
            if (wwe) wired_cur = $urandom_range(0, N - 1);
            op  = tlb_op_t'($urandom_range(0, 3));
            step(r, 1'($urandom_range(0, 1)), op, $urandom_range(0, N - 1), rand_entry(),
                 {19'($urandom_range(0, 4)), 5'd0, 8'($urandom_range(0, 3))}, wwe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
Sequencer for TLB management instructions (TLBR, TLBWI, TLBWR, TLBP) issued from the commit stage toward the TLB array.
- Accepts one request at a time through a valid/ready handshake.
- Drives the TLB read/write/probe ports and returns the result to CP0 through a one-cycle response pulse.
- Owns the CP0 Random register: a decrementing counter bounded below by Wired.

Parameters:
TLB_ENTRIES, `TLB_ENTRIES_NUM (16), number of TLB entries; must be a power of two, at least 2.
IDX_W, $clog2(TLB_ENTRIES), width of an entry index.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_op  in  2  tlb_op_t: 0 TLBR, 1 TLBWI, 2 TLBWR, 3 TLBP
req_index  in  IDX_W  CP0 Index[IDX_W-1:0]; used by TLBR/TLBWI
req_entry  in  tlb_entry_t  entry built from EntryHi/EntryLo0/1/PageMask; used by TLBWI/TLBWR
req_entry_hi  in  32  CP0 EntryHi; used by TLBP
cp0_wired  in  IDX_W  CP0 Wired value
cp0_wired_we  in  1  CP0 is writing Wired this cycle
cp0_random  out  IDX_W  CP0 Random value
tlbrw_index  out  IDX_W  to TLB
tlbrw_we  out  1  to TLB
tlbrw_wdata  out  tlb_entry_t  to TLB
tlbrw_rdata  in  tlb_entry_t  from TLB (combinational)
tlbp_entry_hi  out  32  to TLB
tlbp_index  in  32  from TLB: bit31 = miss, low bits = matching index
resp_valid  out  1  one-cycle completion pulse
resp_op  out  2  op being completed
resp_entry  out  tlb_entry_t  TLBR read data; '0 for other ops
resp_index  out  32  TLBP result; '0 for other ops

Behaviour:
- Clock and reset: a single clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; req_ready 1; tlbrw_we 0; tlbrw_index 0; tlbrw_wdata 0; tlbp_entry_hi 0; resp_valid 0; resp_op 0; resp_entry 0; resp_index 0; cp0_random TLB_ENTRIES-1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, index, entry and entry_hi into operand registers, then go to EXEC.
  - For TLBWR, the index latched is the value of cp0_random in the accept cycle.
- EXEC: TLB outputs are driven from the operand registers only.
  - TLBWI/TLBWR: tlbrw_we=1 for exactly this cycle, with tlbrw_index = latched index and tlbrw_wdata = latched entry.
  - TLBR: tlbrw_index = latched index; tlbrw_rdata is captured at the end of the cycle.
  - TLBP: tlbp_entry_hi = latched entry_hi; tlbp_index is captured at the end of the cycle.
  - Next state is RESP.
- RESP:
  - resp_valid=1 for one cycle; resp_* come from the capture registers.
  - Next state is IDLE.
- Latency: accept in cycle N, TLB access in N+1, resp_valid in N+2. Next accept can happen in N+3 at the earliest. Throughput is one op per 3 cycles.
- tlbrw_we is 0 outside EXEC. tlbrw_index and tlbp_entry_hi hold their last value outside EXEC.
- Random counter, evaluated every cycle:
  - If rst or cp0_wired_we: load TLB_ENTRIES-1.
  - Else if cp0_random == cp0_wired: load TLB_ENTRIES-1. This covers wrap-around and the case Wired == TLB_ENTRIES-1, which holds Random at TLB_ENTRIES-1.
  - Else: decrement by 1.
  - If Wired > Random (illegal Wired), it keeps decrementing and wraps modulo 2^IDX_W. Software must not do this; behaviour is defined only to avoid X.
- Simultaneous events: a cp0_wired_we in the same cycle as a TLBWR accept does not affect that TLBWR. The TLBWR uses the pre-update cp0_random.
- Reset mid-operation: rst in EXEC or RESP aborts. State returns to IDLE and no response is issued. A TLB write already asserted in EXEC has still taken effect at that clock edge.

Optional Feature:
Macro: TLB_CTRL_FLUSH_EN
- Defined: adds output port flush_req (1 bit, reset 0).
  - flush_req pulses in the RESP cycle of TLBWI/TLBWR only, so the front end refetches with the new mapping.
  - req_ready stays low one extra cycle after RESP (state IDLE is delayed by a DRAIN state).
- Undefined: no flush_req port and no DRAIN state; the behaviour above is exact.

Decomposition:
- Shared package (cpu_defs): tlb_op_t enum (TLBR=0, TLBWI=1, TLBWR=2, TLBP=3) and tlb_ctrl_state_t.
- Existing tlb_entry_t, tlb_index_t and `TLB_ENTRIES_NUM are reused.
- Sub-module tlb_random_counter holds the Random/Wired counter (clk, rst, wired, wired_we, random). Everything else stays in tlb_ctrl.

Test Plan:
- Reset: after rst, cp0_random=15; Wired=0 -> Random counts 14,13,...,0,15. With Wired=4, it counts 15..4 then back to 15.
- TLBWI: req_index=5, entry E accepted in cycle N -> tlbrw_we=1, tlbrw_index=5 only in N+1; resp_valid in N+2; req_ready=0 in N+1..N+2.
- TLBR after TLBWI: read index 5 -> resp_entry==E, resp_index=0.
- TLBP: hit on entry 5 -> resp_index=32'h0000_0005. Miss -> resp_index bit31=1.
- TLBWR: cp0_random=9 at accept while cp0_wired_we fires the same cycle -> write goes to index 9; next cycle Random=15.
- rst asserted during EXEC of TLBR -> no resp_valid, req_ready=1 the next cycle; with TLB_CTRL_FLUSH_EN, TLBWI yields flush_req exactly in the RESP cycle.
